// File: rtl/passwd_checker_pkg.sv
// Shared definitions for the password checker: key codes, key decode,
// FSM state encoding and the per-position password digit select.
package passwd_checker_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_CANCEL    = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hB;

    localparam logic [2:0] ENTRY_FULL = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_CHECK = 3'd2,
        ST_OPEN  = 3'd3,
        ST_FAIL  = 3'd4,
        ST_ALARM = 3'd5
    } state_e;

    typedef struct packed {
        logic digit;
        logic cancel;
        logic enter;
    } key_t;

    // Codes 0xC-0xF decode to nothing and are therefore invisible to the FSM.
    function automatic key_t decode_key(
        input logic       valid,
        input logic [3:0] code
    );
        key_t k;
        k.digit  = valid && (code <= KEY_DIGIT_MAX);
        k.cancel = valid && (code == KEY_CANCEL);
        k.enter  = valid && (code == KEY_ENTER);
        return k;
    endfunction

    function automatic logic [3:0] sel_digit(
        input logic [2:0] idx,
        input logic [3:0] d1,
        input logic [3:0] d2,
        input logic [3:0] d3,
        input logic [3:0] d4,
        input logic [3:0] d5,
        input logic [3:0] d6
    );
        logic [3:0] r;
        unique case (idx)
            3'd0:    r = d1;
            3'd1:    r = d2;
            3'd2:    r = d3;
            3'd3:    r = d4;
            3'd4:    r = d5;
            default: r = d6;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/passwd_checker_timer.sv
// Loadable down-counter; done is high during the last counted cycle,
// i.e. N cycles after a load of N.
module cycle_timer
    import passwd_checker_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/passwd_checker.sv
// Six-digit keypad lock: entry, one-cycle check, timed unlock,
// failure counting and a sticky alarm cleared only by clr.
module passwd_checker
    import passwd_checker_pkg::*;
#(
    parameter int unsigned UNLOCK_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned MAX_FAIL       = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [3:0] q1,
    input  logic [3:0] q2,
    input  logic [3:0] q3,
    input  logic [3:0] q4,
    input  logic [3:0] q5,
    input  logic [3:0] q6,
    output logic       unlock,
    output logic       err,
    output logic       alarm,
    output logic [2:0] entry_cnt,
    output logic [1:0] fail_cnt
);

    localparam int unsigned UNL_W = $clog2(UNLOCK_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0]  FAIL_LIMIT = 2'(MAX_FAIL);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] entry_cnt_q;
    logic [2:0] entry_cnt_d;
    logic       mismatch_q;
    logic       mismatch_d;
    logic [1:0] fail_cnt_q;
    logic [1:0] fail_cnt_d;

    key_t       key;
    logic [3:0] exp_digit;
    logic       tmo_load;
    logic       tmo_stop;
    logic       tmo_clr;
    logic       tmo_done;
    logic       unl_load;
    logic       unl_done;

    assign key = decode_key(key_valid, key_code);

    // Password digits are read live so a password update takes effect at once.
    assign exp_digit = sel_digit(entry_cnt_q, q1, q2, q3, q4, q5, q6);

    always_comb begin
        state_d     = state_q;
        entry_cnt_d = entry_cnt_q;
        mismatch_d  = mismatch_q;
        fail_cnt_d  = fail_cnt_q;
        tmo_load    = 1'b0;
        tmo_stop    = 1'b0;
        unl_load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (key.digit) begin
                    state_d     = ST_ENTRY;
                    entry_cnt_d = 3'd1;
                    mismatch_d  = (key_code != q1);
                    tmo_load    = 1'b1;
                end
            end

            ST_ENTRY: begin
                if (key.digit) begin
                    tmo_load = 1'b1;
                    if (entry_cnt_q == ENTRY_FULL) begin
                        mismatch_d = 1'b1;
                    end else begin
                        entry_cnt_d = entry_cnt_q + 3'd1;
                        if (key_code != exp_digit) begin
                            mismatch_d = 1'b1;
                        end
                    end
                end else if (key.enter) begin
                    state_d  = ST_CHECK;
                    tmo_stop = 1'b1;
                end else if (key.cancel || tmo_done) begin
                    state_d     = ST_IDLE;
                    entry_cnt_d = 3'd0;
                    mismatch_d  = 1'b0;
                    tmo_stop    = 1'b1;
                end
            end

            ST_CHECK: begin
                if ((entry_cnt_q == ENTRY_FULL) && !mismatch_q) begin
                    state_d    = ST_OPEN;
                    fail_cnt_d = 2'd0;
                    unl_load   = 1'b1;
                end else begin
                    state_d = ST_FAIL;
                    if (fail_cnt_q != FAIL_LIMIT) begin
                        fail_cnt_d = fail_cnt_q + 2'd1;
                    end
                end
            end

            ST_OPEN: begin
                if (unl_done) begin
                    state_d     = ST_IDLE;
                    entry_cnt_d = 3'd0;
                    mismatch_d  = 1'b0;
                end
            end

            ST_FAIL: begin
                if (fail_cnt_q == FAIL_LIMIT) begin
                    state_d = ST_ALARM;
                end else begin
                    state_d     = ST_IDLE;
                    entry_cnt_d = 3'd0;
                    mismatch_d  = 1'b0;
                end
            end

            ST_ALARM: begin
                state_d = ST_ALARM;
            end

            default: begin
                state_d     = ST_IDLE;
                entry_cnt_d = 3'd0;
                mismatch_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            entry_cnt_q <= 3'd0;
            mismatch_q  <= 1'b0;
            fail_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            entry_cnt_q <= entry_cnt_d;
            mismatch_q  <= mismatch_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign tmo_clr = clr | tmo_stop;

    cycle_timer #(
        .WIDTH    (TMO_W)
    ) u_entry_timer (
        .clk      (clk),
        .clr      (tmo_clr),
        .load     (tmo_load),
        .load_val (TMO_W'(TIMEOUT_CYCLES)),
        .done     (tmo_done)
    );

    cycle_timer #(
        .WIDTH    (UNL_W)
    ) u_unlock_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (unl_load),
        .load_val (UNL_W'(UNLOCK_CYCLES)),
        .done     (unl_done)
    );

    assign unlock    = (state_q == ST_OPEN);
    assign err       = (state_q == ST_FAIL);
    assign alarm     = (state_q == ST_ALARM);
    assign entry_cnt = entry_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_passwd_checker.sv
// Self-checking bench for passwd_checker: vector tables plus
// hand-written multi-cycle sequences, scored through an expect queue.
module tb_passwd_checker;

    typedef struct packed {
        logic       unl;
        logic       err;
        logic       alm;
        logic [2:0] ecnt;
        logic [1:0] fcnt;
        logic       ce;
    } exp_t;

    typedef struct packed {
        logic       kv;
        logic [3:0] kc;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] q1, q2, q3, q4, q5, q6;
    logic       unlock;
    logic       err;
    logic       alarm;
    logic [2:0] entry_cnt;
    logic [1:0] fail_cnt;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t tbl1[$];
    vec_t tbl2[$];
    int   kc;
    int   bad_pw[6];
    int   al_keys[8];

    passwd_checker #(
        .UNLOCK_CYCLES  (16),
        .TIMEOUT_CYCLES (64),
        .MAX_FAIL       (3)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .q1        (q1),
        .q2        (q2),
        .q3        (q3),
        .q4        (q4),
        .q5        (q5),
        .q6        (q6),
        .unlock    (unlock),
        .err       (err),
        .alarm     (alarm),
        .entry_cnt (entry_cnt),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input bit u, input bit e, input bit a,
                                input int ec, input int fc, input bit ce);
        exp_t r;
        r.unl  = u;
        r.err  = e;
        r.alm  = a;
        r.ecnt = 3'(ec);
        r.fcnt = 2'(fc);
        r.ce   = ce;
        return r;
    endfunction

    function automatic vec_t v(input bit kv, input int k,
                               input bit u, input bit e, input bit a,
                               input int ec, input int fc);
        vec_t r;
        r.kv = kv;
        r.kc = 4'(k);
        r.e  = ex(u, e, a, ec, fc, 1'b1);
        return r;
    endfunction

    task automatic apply(input bit c, input bit kv, input logic [3:0] k,
                         input exp_t e, input string nm);
        exp_t x;
        bit   bad;
        clr       = c;
        key_valid = kv;
        key_code  = k;
        sb.push_back(e);
        @(posedge clk);
        #1;
        clr       = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        x = sb.pop_front();
        checks++;
        bad = (unlock !== x.unl) || (err !== x.err) ||
              (alarm !== x.alm) || (fail_cnt !== x.fcnt) ||
              (x.ce && (entry_cnt !== x.ecnt));
        if (bad) begin
            errors++;
            $display("FAIL %s: got unlock=%0b err=%0b alarm=%0b entry_cnt=%0d fail_cnt=%0d, want unlock=%0b err=%0b alarm=%0b entry_cnt=%0d fail_cnt=%0d",
                     nm, unlock, err, alarm, entry_cnt, fail_cnt,
                     x.unl, x.err, x.alm, x.ecnt, x.fcnt);
        end
    endtask

    task automatic go(input bit kv, input int k, input bit u, input bit e,
                      input bit a, input int ec, input int fc,
                      input string nm);
        apply(1'b0, kv, 4'(k), ex(u, e, a, ec, fc, 1'b1), nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want summary before it");
        $fatal(1);
    end

    initial begin
        q1 = 4'd1; q2 = 4'd2; q3 = 4'd3;
        q4 = 4'd4; q5 = 4'd5; q6 = 4'd6;

        // reset with a simultaneous digit: clr wins
        apply(1'b1, 1'b1, 4'h1, ex(0, 0, 0, 0, 0, 1), "reset");

        // ignored codes in IDLE, wrong digit attempt, short attempt,
        // then correct entry with unlock two cycles after enter
        tbl1.push_back(v(1, 14, 0, 0, 0, 0, 0));
        tbl1.push_back(v(1, 10, 0, 0, 0, 0, 0));
        tbl1.push_back(v(1, 11, 0, 0, 0, 0, 0));
        tbl1.push_back(v(0,  0, 0, 0, 0, 0, 0));
        tbl1.push_back(v(1,  1, 0, 0, 0, 1, 0));
        tbl1.push_back(v(1,  2, 0, 0, 0, 2, 0));
        tbl1.push_back(v(1,  9, 0, 0, 0, 3, 0));
        tbl1.push_back(v(1,  4, 0, 0, 0, 4, 0));
        tbl1.push_back(v(1,  5, 0, 0, 0, 5, 0));
        tbl1.push_back(v(1,  6, 0, 0, 0, 6, 0));
        tbl1.push_back(v(1, 11, 0, 0, 0, 6, 0));
        tbl1.push_back(v(0,  0, 0, 1, 0, 6, 1));
        tbl1.push_back(v(0,  0, 0, 0, 0, 0, 1));
        tbl1.push_back(v(1,  1, 0, 0, 0, 1, 1));
        tbl1.push_back(v(1,  2, 0, 0, 0, 2, 1));
        tbl1.push_back(v(1,  3, 0, 0, 0, 3, 1));
        tbl1.push_back(v(1, 11, 0, 0, 0, 3, 1));
        tbl1.push_back(v(0,  0, 0, 1, 0, 3, 2));
        tbl1.push_back(v(0,  0, 0, 0, 0, 0, 2));
        tbl1.push_back(v(1,  1, 0, 0, 0, 1, 2));
        tbl1.push_back(v(1,  2, 0, 0, 0, 2, 2));
        tbl1.push_back(v(1,  3, 0, 0, 0, 3, 2));
        tbl1.push_back(v(1,  4, 0, 0, 0, 4, 2));
        tbl1.push_back(v(1,  5, 0, 0, 0, 5, 2));
        tbl1.push_back(v(1,  6, 0, 0, 0, 6, 2));
        tbl1.push_back(v(1, 11, 0, 0, 0, 6, 2));
        tbl1.push_back(v(0,  0, 1, 0, 0, 6, 0));
        for (int i = 0; i < tbl1.size(); i++) begin
            apply(1'b0, tbl1[i].kv, tbl1[i].kc, tbl1[i].e,
                  $sformatf("tbl1_%0d", i));
        end

        // unlock held 16 cycles in total; keys in OPEN ignored
        for (int i = 2; i <= 16; i++) begin
            kc = (i == 5) ? 1 : (i == 6) ? 11 : (i == 7) ? 10 : 0;
            go((i >= 5) && (i <= 7), kc, 1, 0, 0, 6, 0, "open_hold");
        end
        go(0, 0, 0, 0, 0, 0, 0, "open_end");

        // overflow digit, then cancel with an illegal code mixed in
        tbl2.push_back(v(1,  1, 0, 0, 0, 1, 0));
        tbl2.push_back(v(1,  2, 0, 0, 0, 2, 0));
        tbl2.push_back(v(1,  3, 0, 0, 0, 3, 0));
        tbl2.push_back(v(1,  4, 0, 0, 0, 4, 0));
        tbl2.push_back(v(1,  5, 0, 0, 0, 5, 0));
        tbl2.push_back(v(1,  6, 0, 0, 0, 6, 0));
        tbl2.push_back(v(1,  7, 0, 0, 0, 6, 0));
        tbl2.push_back(v(1, 11, 0, 0, 0, 6, 0));
        tbl2.push_back(v(0,  0, 0, 1, 0, 6, 1));
        tbl2.push_back(v(0,  0, 0, 0, 0, 0, 1));
        tbl2.push_back(v(1,  1, 0, 0, 0, 1, 1));
        tbl2.push_back(v(1,  2, 0, 0, 0, 2, 1));
        tbl2.push_back(v(1, 14, 0, 0, 0, 2, 1));
        tbl2.push_back(v(1, 10, 0, 0, 0, 0, 1));
        tbl2.push_back(v(1, 14, 0, 0, 0, 0, 1));
        tbl2.push_back(v(0,  0, 0, 0, 0, 0, 1));
        for (int i = 0; i < tbl2.size(); i++) begin
            apply(1'b0, tbl2[i].kv, tbl2[i].kc, tbl2[i].e,
                  $sformatf("tbl2_%0d", i));
        end

        // timeout after 64 idle cycles; illegal key does not restart it
        go(1, 1, 0, 0, 0, 1, 1, "to_k1");
        go(1, 2, 0, 0, 0, 2, 1, "to_k2");
        go(1, 3, 0, 0, 0, 3, 1, "to_k3");
        for (int j = 1; j <= 64; j++) begin
            go(j == 30, (j == 30) ? 15 : 0, 0, 0, 0,
               (j == 64) ? 0 : 3, 1, "timeout");
        end

        // digit on the expiry cycle wins and restarts the timer
        go(1, 1, 0, 0, 0, 1, 1, "exp_k1");
        go(1, 2, 0, 0, 0, 2, 1, "exp_k2");
        go(1, 3, 0, 0, 0, 3, 1, "exp_k3");
        for (int j = 1; j <= 63; j++) begin
            go(0, 0, 0, 0, 0, 3, 1, "exp_wait");
        end
        go(1, 4, 0, 0, 0, 4, 1, "expiry_key");
        for (int j = 1; j <= 64; j++) begin
            go(0, 0, 0, 0, 0, (j == 64) ? 0 : 4, 1, "timeout2");
        end

        // password changed mid-entry is used live; clr mid-OPEN
        go(1, 1, 0, 0, 0, 1, 1, "live_k1");
        go(1, 2, 0, 0, 0, 2, 1, "live_k2");
        go(1, 3, 0, 0, 0, 3, 1, "live_k3");
        q4 = 4'd7;
        go(1, 7, 0, 0, 0, 4, 1, "live_k4");
        go(1, 5, 0, 0, 0, 5, 1, "live_k5");
        go(1, 6, 0, 0, 0, 6, 1, "live_k6");
        go(1, 11, 0, 0, 0, 6, 1, "live_enter");
        go(0, 0, 1, 0, 0, 6, 0, "live_open");
        go(0, 0, 1, 0, 0, 6, 0, "live_open2");
        apply(1'b1, 1'b1, 4'h1, ex(0, 0, 0, 0, 0, 1), "clr_open");
        q4 = 4'd4;
        go(0, 0, 0, 0, 0, 0, 0, "after_clr");

        // three consecutive failures lead to ALARM
        bad_pw = '{1, 2, 9, 4, 5, 6};
        for (int r = 1; r <= 3; r++) begin
            for (int i = 0; i < 6; i++) begin
                go(1, bad_pw[i], 0, 0, 0, i + 1, r - 1, "al_digit");
            end
            go(1, 11, 0, 0, 0, 6, r - 1, "al_enter");
            go(0, 0, 0, 1, 0, 6, r, "al_fail");
            if (r < 3) begin
                go(0, 0, 0, 0, 0, 0, r, "al_idle");
            end
        end
        apply(1'b0, 1'b0, 4'h0, ex(0, 0, 1, 0, 3, 0), "alarm_on");
        al_keys = '{1, 2, 3, 4, 5, 6, 11, 10};
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, 4'(al_keys[i]), ex(0, 0, 1, 0, 3, 0),
                  "alarm_keys");
        end
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b0, 4'h0, ex(0, 0, 1, 0, 3, 0), "alarm_hold");
        end
        apply(1'b1, 1'b0, 4'h0, ex(0, 0, 0, 0, 0, 1), "clr_alarm");
        go(0, 0, 0, 0, 0, 0, 0, "post_clr");
        go(1, 5, 0, 0, 0, 1, 0, "post_clr_key");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
